// File: rtl/cmp_seq_pkg.sv
// rtl/cmp_seq_pkg.sv - shared types and constants for the BCD compare sequencer
package cmp_seq_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIN  = 2'd2
  } state_t;

  // Bit positions of the comparator result {GT,EQ,LT}
  localparam int Q_GT = 2;
  localparam int Q_EQ = 1;
  localparam int Q_LT = 0;

  localparam logic [3:0] BCD_MAX  = 4'd9;
  localparam logic [2:0] RES_NONE = 3'b000;

  // A comparator answer is only trusted when exactly one of GT/EQ/LT is set
  function automatic logic onehot3(input logic [2:0] q);
    return (q == 3'b100) || (q == 3'b010) || (q == 3'b001);
  endfunction

endpackage

// File: rtl/bcd_operand_check.sv
// rtl/bcd_operand_check.sv - flags any non-BCD nibble in either operand
module bcd_operand_check
  import cmp_seq_pkg::*;
#(
  parameter int DIGITS = 4
) (
  input  logic [4*DIGITS-1:0] a,
  input  logic [4*DIGITS-1:0] b,
  output logic                bad
);

  // Any nibble above 9 in either operand makes the whole request invalid
  always_comb begin
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if ((a[i*4 +: 4] > BCD_MAX) || (b[i*4 +: 4] > BCD_MAX)) begin
        bad = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cmp_seq.sv
// rtl/cmp_seq.sv - multi-digit BCD magnitude compare using one shared digit comparator
module cmp_seq
  import cmp_seq_pkg::*;
#(
  parameter int  DIGITS = 4,
  localparam int IDXW   = $clog2(DIGITS) + 1
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                START,
  input  logic [4*DIGITS-1:0] A_NUM,
  input  logic [4*DIGITS-1:0] B_NUM,
  output logic [3:0]          CMP_A,
  output logic [3:0]          CMP_B,
  input  logic [2:0]          CMP_Q,
  output logic                BUSY,
  output logic                DONE,
  output logic [2:0]          RESULT,
  output logic                ERR,
  output logic [IDXW-1:0]     DIG_IDX
);

  state_t              state;
  state_t              state_nxt;
  logic [4*DIGITS-1:0] a_lat;
  logic [4*DIGITS-1:0] b_lat;
  logic [4*DIGITS-1:0] a_nxt;
  logic [4*DIGITS-1:0] b_nxt;
  logic [3:0]          cmp_a_nxt;
  logic [3:0]          cmp_b_nxt;
  logic [IDXW-1:0]     idx_nxt;
  logic [IDXW-1:0]     idx_dec;
  logic [3:0]          lo_a;
  logic [3:0]          lo_b;
  logic [2:0]          result_nxt;
  logic                err_nxt;
  logic                bad;

  bcd_operand_check #(
    .DIGITS(DIGITS)
  ) u_check (
    .a   (A_NUM),
    .b   (B_NUM),
    .bad (bad)
  );

  // BUSY covers the digit-walking phase; DONE is the single FIN cycle
  assign BUSY = (state == RUN);
  assign DONE = (state == FIN);

  // Next state and next register contents; FIN accepts START like IDLE
  always_comb begin
    state_nxt  = state;
    a_nxt      = a_lat;
    b_nxt      = b_lat;
    cmp_a_nxt  = CMP_A;
    cmp_b_nxt  = CMP_B;
    idx_nxt    = DIG_IDX;
    result_nxt = RESULT;
    err_nxt    = ERR;
    idx_dec    = DIG_IDX - IDXW'(1);
    lo_a       = 4'd0;
    lo_b       = 4'd0;
    // Select the next lower digit pair from the latched operands
    for (int i = 0; i < DIGITS; i++) begin
      if (idx_dec == IDXW'(i)) begin
        lo_a = a_lat[i*4 +: 4];
        lo_b = b_lat[i*4 +: 4];
      end
    end

    case (state)
      IDLE, FIN: begin
        state_nxt = IDLE;
        if (START) begin
          a_nxt = A_NUM;
          b_nxt = B_NUM;
          if (bad) begin
            // Reject without touching the comparator inputs
            result_nxt = RES_NONE;
            err_nxt    = 1'b1;
            state_nxt  = FIN;
          end else begin
            cmp_a_nxt = A_NUM[4*DIGITS-1 -: 4];
            cmp_b_nxt = B_NUM[4*DIGITS-1 -: 4];
            idx_nxt   = IDXW'(DIGITS - 1);
            state_nxt = RUN;
          end
        end
      end
      RUN: begin
        if (!onehot3(CMP_Q)) begin
          result_nxt = RES_NONE;
          err_nxt    = 1'b1;
          state_nxt  = FIN;
        end else if (CMP_Q[Q_GT] || CMP_Q[Q_LT]) begin
          result_nxt = CMP_Q;
          err_nxt    = 1'b0;
          state_nxt  = FIN;
        end else if (DIG_IDX == '0) begin
          // Every digit matched down to the least significant one
          result_nxt = CMP_Q;
          err_nxt    = 1'b0;
          state_nxt  = FIN;
        end else begin
          idx_nxt   = idx_dec;
          cmp_a_nxt = lo_a;
          cmp_b_nxt = lo_b;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= IDLE;
      a_lat   <= '0;
      b_lat   <= '0;
      CMP_A   <= 4'd0;
      CMP_B   <= 4'd0;
      DIG_IDX <= '0;
      RESULT  <= RES_NONE;
      ERR     <= 1'b0;
    end else begin
      state   <= state_nxt;
      a_lat   <= a_nxt;
      b_lat   <= b_nxt;
      CMP_A   <= cmp_a_nxt;
      CMP_B   <= cmp_b_nxt;
      DIG_IDX <= idx_nxt;
      RESULT  <= result_nxt;
      ERR     <= err_nxt;
    end
  end

endmodule
